// File: rtl/pc_pkg.sv
// Shared CPU package: program-counter FSM state encoding and PC reset value.
// Imported by pc and any other CPU block that needs to reason about PC state.
package pc_pkg;

    // Two-state program-counter sequencer.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } pc_state_e;

    // Value the PC takes on reset, on halt and while idle.
    localparam int unsigned PcResetValue = 0;

endpackage

// File: rtl/pc.sv
// Program counter with an IDLE/RUN sequencer.
//
// Ports:
//   i_clk       clock, all state updates on its rising edge
//   i_reset     asynchronous active-low reset (PC -> 0, FSM -> IDLE)
//   i_start     start request, IDLE -> RUN
//   i_halt      halt request, clears PC and returns to IDLE (highest priority)
//   i_not_load  load inhibit; in RUN the PC holds while high
//   i_enable    global clock enable; when low all state holds
//   i_next_pc   externally computed next PC, loaded verbatim in RUN
//   o_pc        current PC, straight from a register
module pc
    import pc_pkg::*;
#(
    parameter int unsigned PC_SIZE = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_halt,
    input  logic               i_not_load,
    input  logic               i_enable,
    input  logic [PC_SIZE-1:0] i_next_pc,
    output logic [PC_SIZE-1:0] o_pc
);

    localparam logic [PC_SIZE-1:0] PcReset = PC_SIZE'(PcResetValue);

    pc_state_e          state_q;
    logic [PC_SIZE-1:0] pc_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            pc_q    <= PcReset;
        end else if (i_enable) begin
            if (i_halt) begin
                // Halt wins over start and load inhibit.
                state_q <= StIdle;
                pc_q    <= PcReset;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // PC stays cleared on the start edge; loading begins next edge.
                        pc_q <= PcReset;
                        if (i_start) begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (!i_not_load) begin
                            pc_q <= i_next_pc;
                        end
                    end
                endcase
            end
        end
    end

    assign o_pc = pc_q;

endmodule

// File: tb/tb_pc.sv
module tb_pc;

    localparam int unsigned PcSize = 32;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              halt     = 1'b0;
    logic              not_load = 1'b0;
    logic              enable   = 1'b0;
    logic [PcSize-1:0] next_pc  = '0;
    logic [PcSize-1:0] pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state and scoreboard of expected o_pc values.
    logic              m_run = 1'b0;
    logic [PcSize-1:0] m_pc  = '0;
    logic [PcSize-1:0] exp_q[$];

    pc #(
        .PC_SIZE(PcSize)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (start),
        .i_halt    (halt),
        .i_not_load(not_load),
        .i_enable  (enable),
        .i_next_pc (next_pc),
        .o_pc      (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [PcSize-1:0] act,
                            input logic [PcSize-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: o_pc got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the DUT output.
    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, o_pc got %0d expected a value", tag, pc_out);
        end else begin
            check_eq(tag, pc_out, exp_q.pop_front());
        end
    endtask

    // Drive one cycle of stimulus, predict the result, then check after the edge.
    task automatic cycle(input string tag, input logic s, input logic h, input logic nl,
                         input logic en, input logic [PcSize-1:0] npc);
        @(negedge clk);
        start    = s;
        halt     = h;
        not_load = nl;
        enable   = en;
        next_pc  = npc;
        if (en) begin
            if (h) begin
                m_run = 1'b0;
                m_pc  = '0;
            end else if (!m_run) begin
                m_pc = '0;
                if (s) m_run = 1'b1;
            end else if (!nl) begin
                m_pc = npc;
            end
        end
        exp_q.push_back(m_pc);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        // Reset held across a few edges.
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back('0);
        pop_check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Start, then load 1..10.
        cycle("start_edge", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 1; i <= 10; i++) cycle("run_load", 1'b0, 1'b0, 1'b0, 1'b1, i);

        // Enable low: everything holds.
        for (int i = 11; i <= 20; i++) cycle("enable_low", 1'b0, 1'b0, 1'b0, 1'b0, i);

        // Halt, then IDLE ignores next_pc.
        cycle("halt_edge", 1'b0, 1'b1, 1'b0, 1'b1, 32'd20);
        for (int i = 21; i <= 25; i++) cycle("idle_ignore", 1'b0, 1'b0, 1'b0, 1'b1, i);

        // Restart, load to 35, stall to 40, resume to 45.
        cycle("restart", 1'b1, 1'b0, 1'b0, 1'b1, 32'd25);
        for (int i = 26; i <= 35; i++) cycle("reload", 1'b0, 1'b0, 1'b0, 1'b1, i);
        for (int i = 36; i <= 40; i++) cycle("stall", 1'b0, 1'b0, 1'b1, 1'b1, i);
        for (int i = 41; i <= 45; i++) cycle("resume", 1'b0, 1'b0, 1'b0, 1'b1, i);

        // Start while running has no effect; with a stall it holds, otherwise loads.
        cycle("start_in_run_hold", 1'b1, 1'b0, 1'b1, 1'b1, 32'd99);
        cycle("start_in_run_load", 1'b1, 1'b0, 1'b0, 1'b1, 32'd45);

        // Halt from RUN at 45; halt beats not_load.
        cycle("halt_from_run", 1'b0, 1'b1, 1'b1, 1'b1, 32'd46);

        // Back into RUN, then asynchronous reset between edges.
        cycle("start_again", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        cycle("load_before_rst", 1'b0, 1'b0, 1'b0, 1'b1, 32'hdead_beef);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_run = 1'b0;
        m_pc  = '0;
        exp_q.push_back('0);
        pop_check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start and halt together: halt wins, stays IDLE.
        cycle("start_halt_same", 1'b1, 1'b1, 1'b0, 1'b1, 32'd77);
        cycle("still_idle", 1'b0, 1'b0, 1'b0, 1'b1, 32'd78);

        // Full-width load of an all-ones value.
        cycle("start_wide", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        cycle("load_wide", 1'b0, 1'b0, 1'b0, 1'b1, 32'hffff_ffff);

        // Random mix of controls checked against the model.
        for (int i = 0; i < 60; i++) begin
            cycle("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) != 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
